// File: rtl/wb_spi_bridge.sv
// Wishbone classic slave that turns register accesses into single-cycle SPI interface strobes.
// Optional WAIT watchdog is built only when WB_SPI_TIMEOUT_EN is defined.
module wb_spi_bridge #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [1:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o,
  output logic [10:0] if_din,
  output logic        if_cmd,
  output logic        if_wr,
  output logic        if_rd,
  input  logic [8:0]  if_dout,
  input  logic        if_ack
);

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StDone, StErr} state_e;

  state_e      state_q, state_d;
  logic [1:0]  adr_q, adr_d;
  logic        we_q, we_d;
  logic [10:0] if_din_q, if_din_d;
  logic        cmd_q, cmd_d, wr_q, wr_d, rd_q, rd_d;
  logic        ack_q, ack_d, err_q, err_d;
  logic [31:0] dat_q, dat_d;
  logic [10:0] cfg_q, cfg_d;
`ifdef WB_SPI_TIMEOUT_EN
  logic [7:0]  cnt_q, cnt_d;
`endif

  logic unused_sig;
  assign unused_sig = ^{wb_dat_i[31:11], TIMEOUT[0]};

  always_comb begin
    state_d  = state_q;
    adr_d    = adr_q;
    we_d     = we_q;
    if_din_d = if_din_q;
    cmd_d    = 1'b0;
    wr_d     = 1'b0;
    rd_d     = 1'b0;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    dat_d    = dat_q;
    cfg_d    = cfg_q;
`ifdef WB_SPI_TIMEOUT_EN
    cnt_d    = cnt_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (wb_cyc_i && wb_stb_i) begin
          adr_d    = wb_adr_i;
          we_d     = wb_we_i;
          if_din_d = wb_dat_i[10:0];
          unique case (wb_adr_i)
            2'd0: begin
              state_d = StIssue;
              wr_d    = wb_we_i;
              rd_d    = !wb_we_i;
            end
            2'd1: begin
              state_d = StIssue;
              cmd_d   = wb_we_i;
            end
            2'd2: begin
              if (!wb_we_i) begin
                state_d = StDone;
                ack_d   = 1'b1;
                dat_d   = {21'b0, cfg_q};
              end else begin
                state_d = StErr;
                err_d   = 1'b1;
              end
            end
            default: begin
              state_d = StErr;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      StIssue: begin
        if (!wb_cyc_i) begin
          state_d = StIdle;
        end else if (adr_q == 2'd1 && !we_q) begin
          // CONFIG read is served from the shadow without touching the interface
          state_d = StDone;
          ack_d   = 1'b1;
          dat_d   = {21'b0, cfg_q};
        end else begin
          state_d = StWait;
`ifdef WB_SPI_TIMEOUT_EN
          cnt_d   = 8'd0;
`endif
        end
      end
      StWait: begin
        if (!wb_cyc_i) begin
          state_d = StIdle;
        end else if (if_ack) begin
          state_d = StDone;
          ack_d   = 1'b1;
          if (!we_q) dat_d = {23'b0, if_dout};
          if (adr_q == 2'd1 && we_q) cfg_d = if_din_q;
        end
`ifdef WB_SPI_TIMEOUT_EN
        else if (cnt_q == 8'(TIMEOUT - 1)) begin
          state_d = StErr;
          err_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
`endif
      end
      StDone:  state_d = StIdle;
      StErr:   state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      adr_q    <= 2'd0;
      we_q     <= 1'b0;
      if_din_q <= 11'd0;
      cmd_q    <= 1'b0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      ack_q    <= 1'b0;
      err_q    <= 1'b0;
      dat_q    <= 32'd0;
      cfg_q    <= 11'd0;
`ifdef WB_SPI_TIMEOUT_EN
      cnt_q    <= 8'd0;
`endif
    end else begin
      state_q  <= state_d;
      adr_q    <= adr_d;
      we_q     <= we_d;
      if_din_q <= if_din_d;
      cmd_q    <= cmd_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      ack_q    <= ack_d;
      err_q    <= err_d;
      dat_q    <= dat_d;
      cfg_q    <= cfg_d;
`ifdef WB_SPI_TIMEOUT_EN
      cnt_q    <= cnt_d;
`endif
    end
  end

  assign wb_dat_o = dat_q;
  assign wb_ack_o = ack_q;
  assign wb_err_o = err_q;
  assign if_din   = if_din_q;
  assign if_cmd   = cmd_q;
  assign if_wr    = wr_q;
  assign if_rd    = rd_q;

endmodule

// File: tb/tb_wb_spi_bridge.sv
// Bench for wb_spi_bridge: directed vector table, reset/abort sequences and random transactions
// scored against a transaction-level model. Define WB_SPI_TIMEOUT_EN to exercise the watchdog.
module tb_wb_spi_bridge;
  localparam int unsigned TbTo = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [1:0]  adr = 2'd0;
  logic [31:0] dat_i = 32'd0;
  logic [31:0] dat_o;
  logic        ack_o, err_o;
  logic [10:0] if_din;
  logic        if_cmd, if_wr, if_rd;
  logic [8:0]  if_dout = 9'd0;
  logic        if_ack = 1'b0;

  wb_spi_bridge #(.TIMEOUT(TbTo)) dut (
    .clk(clk), .rst(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we), .wb_adr_i(adr),
    .wb_dat_i(dat_i), .wb_dat_o(dat_o), .wb_ack_o(ack_o), .wb_err_o(err_o), .if_din(if_din),
    .if_cmd(if_cmd), .if_wr(if_wr), .if_rd(if_rd), .if_dout(if_dout), .if_ack(if_ack)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [10:0] m_cfg = 11'd0;
  logic [31:0] m_dat = 32'd0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_dat"}, dat_o, 32'd0);
    check({name, "_term"}, {30'd0, ack_o, err_o}, 32'd0);
    check({name, "_din"}, {21'd0, if_din}, 32'd0);
    check({name, "_strb"}, {29'd0, if_cmd, if_wr, if_rd}, 32'd0);
  endtask

  // dly: cycles from strobe to if_ack; 0 means the interface never acknowledges
  task automatic do_txn(input logic [1:0] a, input logic w, input logic [31:0] d, input int dly,
                        input logic [8:0] rx, output logic t_err, output logic [31:0] rdat);
    int strobe_n = 0, strobes = 0, term_n = 0, e_term = 0;
    logic [2:0] kind = 3'd0, e_kind = 3'd0;
    logic [10:0] din_seen = 11'd0, e_cfg;
    logic err_s = 1'b0, both = 1'b0, e_err = 1'b0;
    logic [31:0] e_dat;
    e_dat = m_dat;
    e_cfg = m_cfg;
    rdat  = 32'd0;
    if (a == 2'd3 || (a == 2'd2 && w)) begin
      e_err = 1'b1; e_term = 1;
    end else if (a == 2'd2) begin
      e_term = 1; e_dat = {21'd0, m_cfg};
    end else if (a == 2'd1 && !w) begin
      e_term = 2; e_dat = {21'd0, m_cfg};
    end else begin
      e_kind = (a == 2'd1) ? 3'b100 : (w ? 3'b010 : 3'b001);
      if (dly == 0) begin
        e_err = 1'b1; e_term = TbTo + 2;
      end else begin
        e_term = dly + 2;
        if (!w) e_dat = {23'd0, rx};
        if (a == 2'd1) e_cfg = d[10:0];
      end
    end
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; adr = a; we = w; dat_i = d;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if_ack  = (strobe_n > 0 && dly > 0 && n == strobe_n + dly);
      if_dout = rx;
      @(negedge clk);
      if (if_cmd || if_wr || if_rd) begin
        strobes++; strobe_n = n; kind = {if_cmd, if_wr, if_rd}; din_seen = if_din;
      end
      if (ack_o && err_o) both = 1'b1;
      if (ack_o || err_o) begin
        term_n = n; err_s = err_o; rdat = dat_o;
        break;
      end
    end
    if (term_n == 0) check("txn_budget", 32'd0, 32'd1);
    @(posedge clk); #1;
    cyc = 1'b0; stb = 1'b0; if_ack = 1'b0;
    @(negedge clk);
    check("term_one_cycle", {30'd0, ack_o, err_o}, 32'd0);
    check("dat_hold", dat_o, e_dat);
    check("term_cycle", term_n, e_term);
    check("term_kind", {31'd0, err_s}, {31'd0, e_err});
    check("no_both", {31'd0, both}, 32'd0);
    check("strobe_count", strobes, (e_kind != 3'd0) ? 1 : 0);
    check("strobe_kind", {29'd0, kind}, {29'd0, e_kind});
    if (e_kind != 3'd0) begin
      check("strobe_cycle", strobe_n, 1);
      check("strobe_din", {21'd0, din_seen}, {21'd0, d[10:0]});
    end
    if (!e_err) check("rdata", rdat, e_dat);
    m_dat = e_dat;
    m_cfg = e_cfg;
    t_err = err_s;
  endtask

  typedef struct {
    logic [1:0]  adr;
    logic        we;
    logic [31:0] dat;
    int          dly;
    logic [8:0]  rx;
    logic        exp_err;
    logic        chk_dat;
    logic [31:0] exp_dat;
  } vec_t;

  vec_t vecs[11];
  logic t_err;
  logic [31:0] rdat;

  initial begin
    vecs[0]  = '{2'd0, 1'b1, 32'h0000_01A5, 1, 9'h000, 1'b0, 1'b0, 32'h0};
    vecs[1]  = '{2'd1, 1'b1, 32'h0000_00FD, 1, 9'h000, 1'b0, 1'b0, 32'h0};
    vecs[2]  = '{2'd2, 1'b0, 32'h0,         1, 9'h000, 1'b0, 1'b1, 32'h0000_00FD};
    vecs[3]  = '{2'd1, 1'b0, 32'h0,         1, 9'h000, 1'b0, 1'b1, 32'h0000_00FD};
    vecs[4]  = '{2'd0, 1'b0, 32'h0,         1, 9'h05A, 1'b0, 1'b1, 32'h0000_005A};
    vecs[5]  = '{2'd0, 1'b0, 32'h0,         3, 9'h100, 1'b0, 1'b1, 32'h0000_0100};
    vecs[6]  = '{2'd3, 1'b0, 32'h0,         1, 9'h000, 1'b1, 1'b0, 32'h0};
    vecs[7]  = '{2'd3, 1'b1, 32'h0000_0123, 1, 9'h000, 1'b1, 1'b0, 32'h0};
    vecs[8]  = '{2'd2, 1'b1, 32'h0000_0456, 1, 9'h000, 1'b1, 1'b0, 32'h0};
    vecs[9]  = '{2'd1, 1'b1, 32'hFFFF_F7FF, 2, 9'h000, 1'b0, 1'b0, 32'h0};
    vecs[10] = '{2'd2, 1'b0, 32'h0,         1, 9'h000, 1'b0, 1'b1, 32'h0000_07FF};

    #2;
    check_all_zero("reset");
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      do_txn(vecs[i].adr, vecs[i].we, vecs[i].dat, vecs[i].dly, vecs[i].rx, t_err, rdat);
      check($sformatf("vec%0d_err", i), {31'd0, t_err}, {31'd0, vecs[i].exp_err});
      if (vecs[i].chk_dat) check($sformatf("vec%0d_dat", i), rdat, vecs[i].exp_dat);
    end

    // Reset in WAIT: outputs clear at once, shadow and read data are lost
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; adr = 2'd0; we = 1'b1; dat_i = 32'h055;
    @(posedge clk); @(posedge clk); #3;
    rst = 1'b1;
    #1 check_all_zero("midreset");
    cyc = 1'b0; stb = 1'b0;
    @(posedge clk); #1 rst = 1'b0;
    m_cfg = 11'd0; m_dat = 32'd0;
    do_txn(2'd0, 1'b1, 32'h2AA, 2, 9'h000, t_err, rdat);
    do_txn(2'd2, 1'b0, 32'h0, 1, 9'h000, t_err, rdat);
    check("cfg_after_reset", rdat, 32'd0);

    // Abort in WAIT, then a stray if_ack in IDLE must be ignored
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; adr = 2'd0; we = 1'b1; dat_i = 32'h033;
`ifdef WB_SPI_TIMEOUT_EN
    repeat (3) begin
`else
    repeat (30) begin
`endif
      @(negedge clk);
      check("wait_no_term", {30'd0, ack_o, err_o}, 32'd0);
    end
    @(posedge clk); #1 cyc = 1'b0; stb = 1'b0;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1 if_ack = (n == 1); if_dout = 9'h0AB;
      @(negedge clk);
      check("abort_no_term", {30'd0, ack_o, err_o}, 32'd0);
      check("abort_no_strb", {29'd0, if_cmd, if_wr, if_rd}, 32'd0);
    end
    if_ack = 1'b0;
    check("abort_dat_hold", dat_o, m_dat);

`ifdef WB_SPI_TIMEOUT_EN
    do_txn(2'd0, 1'b1, 32'h0F0, 0, 9'h000, t_err, rdat);
    check("timeout_err", {31'd0, t_err}, 32'd1);
`endif

    for (int i = 0; i < 40; i++) begin
      do_txn(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), $urandom,
             int'($urandom_range(1, TbTo)), 9'($urandom_range(0, 511)), t_err, rdat);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
endmodule
